// File: rtl/stdcore_pkg.sv
// Shared stdcore definitions: elaboration-time helpers used across the stdcore blocks.
package stdcore_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/stdcore_lanesel.sv
// Combinational lane selector: picks lane sel out of an N-lane packed word.
module stdcore_lanesel
  import stdcore_pkg::*;
#(
  parameter int DW = 8,
  parameter int N  = 4,
  localparam int CW = clog2((N < 2) ? 2 : N)
) (
  input  logic [DW*N-1:0] word,
  input  logic [CW-1:0]   sel,
  output logic [DW-1:0]   lane
);

  always_comb begin
    lane = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (sel == CW'(k)) lane = word[k*DW +: DW];
    end
  end

endmodule

// File: rtl/stdcore_unpack.sv
// Stream width down-converter: accepts one N-lane word, emits it lane by lane
// (lane 0 first) with a last-lane flag; supports partial words via p_cnt.
module stdcore_unpack
  import stdcore_pkg::*;
#(
  parameter int DW = 8,
  parameter int N  = 4,
  localparam int CW = clog2((N < 2) ? 2 : N)
) (
  input  logic            clk,
  input  logic            arst,
  input  logic [DW*N-1:0] p,
  input  logic [CW-1:0]   p_cnt,
  input  logic            p_val,
  output logic            p_rdy,
  output logic [DW-1:0]   c,
  output logic            c_last,
  output logic            c_val,
  input  logic            c_rdy
);

  if (N < 1 || DW < 1) begin : g_param_err
    $error("stdcore_unpack: N and DW must both be >= 1");
  end

  typedef enum logic {EMPTY, BUSY} state_t;

  state_t          state_q, state_d;
  logic [DW*N-1:0] word_q, word_d;
  logic [CW-1:0]   last_q, last_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_clamp;
  logic            full, at_last, accept, xfer;

  assign full      = (state_q == BUSY);
  assign at_last   = (idx_q == last_q);
  assign cnt_clamp = (p_cnt > CW'(N - 1)) ? CW'(N - 1) : p_cnt;

  // p_rdy depends only on registers and c_rdy, never on p_val.
  assign p_rdy  = !full || (c_rdy && at_last);
  assign accept = p_val && p_rdy;
  assign xfer   = full && c_rdy;

  assign c_val  = full;
  assign c_last = full && at_last;

  stdcore_lanesel #(.DW(DW), .N(N)) u_lanesel (
    .word (word_q),
    .sel  (idx_q),
    .lane (c)
  );

  // A load in the same cycle as the final lane transfer wins, giving a gapless handoff.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    idx_d   = idx_q;
    if (accept) begin
      state_d = BUSY;
      word_d  = p;
      last_d  = cnt_clamp;
      idx_d   = '0;
    end else if (xfer) begin
      if (at_last) begin
        state_d = EMPTY;
        idx_d   = '0;
      end else begin
        idx_d   = idx_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= EMPTY;
      word_q  <= '0;
      last_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_stdcore_unpack.sv
// Directed bench for stdcore_unpack: N=4 main instance plus an N=3 instance for count clamping.
module tb_stdcore_unpack;

  logic        clk;
  logic        arst;

  logic [31:0] p;
  logic [1:0]  p_cnt;
  logic        p_val, p_rdy;
  logic [7:0]  c;
  logic        c_last, c_val, c_rdy;

  logic [23:0] p3;
  logic [1:0]  p3_cnt;
  logic        p3_val, p3_rdy;
  logic [7:0]  c3;
  logic        c3_last, c3_val, c3_rdy;

  int checks;
  int failures;

  stdcore_unpack #(.DW(8), .N(4)) u_dut (
    .clk(clk), .arst(arst), .p(p), .p_cnt(p_cnt), .p_val(p_val), .p_rdy(p_rdy),
    .c(c), .c_last(c_last), .c_val(c_val), .c_rdy(c_rdy)
  );

  stdcore_unpack #(.DW(8), .N(3)) u_dut3 (
    .clk(clk), .arst(arst), .p(p3), .p_cnt(p3_cnt), .p_val(p3_val), .p_rdy(p3_rdy),
    .c(c3), .c_last(c3_last), .c_val(c3_val), .c_rdy(c3_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Main-instance output snapshot; c compared only while valid.
  task automatic outs(input string tag, input logic [7:0] ec, input logic el,
                      input logic ev, input logic er);
    #1;
    chk({tag, ".c_val"}, {31'b0, c_val}, {31'b0, ev});
    chk({tag, ".c_last"}, {31'b0, c_last}, {31'b0, el});
    chk({tag, ".p_rdy"}, {31'b0, p_rdy}, {31'b0, er});
    if (ev) chk({tag, ".c"}, {24'b0, c}, {24'b0, ec});
  endtask

  task automatic outs3(input string tag, input logic [7:0] ec, input logic el, input logic ev);
    #1;
    chk({tag, ".c_val"}, {31'b0, c3_val}, {31'b0, ev});
    chk({tag, ".c_last"}, {31'b0, c3_last}, {31'b0, el});
    if (ev) chk({tag, ".c"}, {24'b0, c3}, {24'b0, ec});
  endtask

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    arst   = 1'b0;
    p      = '0; p_cnt  = '0; p_val  = 1'b0; c_rdy  = 1'b1;
    p3     = '0; p3_cnt = '0; p3_val = 1'b0; c3_rdy = 1'b1;

    // Reset applied before the first clock edge takes effect immediately.
    #2 arst = 1'b1;
    #1;
    chk("rst.c_val", {31'b0, c_val}, 32'd0);
    chk("rst.c_last", {31'b0, c_last}, 32'd0);
    chk("rst.p_rdy", {31'b0, p_rdy}, 32'd1);
    chk("rst.c", {24'b0, c}, 32'd0);
    repeat (2) @(posedge clk);
    #3 arst = 1'b0;
    repeat (5) tk();
    outs("idle", 8'h00, 1'b0, 1'b0, 1'b1);
    chk("idle.c", {24'b0, c}, 32'd0);

    // Full word with c_rdy held high.
    p = 32'h44332211; p_cnt = 2'd3; p_val = 1'b1;
    outs("full.t0", 8'h00, 1'b0, 1'b0, 1'b1);
    tk(); p_val = 1'b0;
    outs("full.l0", 8'h11, 1'b0, 1'b1, 1'b0);
    tk(); outs("full.l1", 8'h22, 1'b0, 1'b1, 1'b0);
    tk(); outs("full.l2", 8'h33, 1'b0, 1'b1, 1'b0);
    tk(); outs("full.l3", 8'h44, 1'b1, 1'b1, 1'b1);
    tk(); outs("full.done", 8'h00, 1'b0, 1'b0, 1'b1);

    // Back-to-back words, second one loaded on the last lane of the first.
    p = 32'h44332211; p_cnt = 2'd3; p_val = 1'b1;
    tk(); p = 32'hDDCCBBAA; p_cnt = 2'd1;
    outs("b2b.11", 8'h11, 1'b0, 1'b1, 1'b0);
    tk(); outs("b2b.22", 8'h22, 1'b0, 1'b1, 1'b0);
    tk(); outs("b2b.33", 8'h33, 1'b0, 1'b1, 1'b0);
    tk(); outs("b2b.44", 8'h44, 1'b1, 1'b1, 1'b1);
    tk(); p_val = 1'b0;
    outs("b2b.AA", 8'hAA, 1'b0, 1'b1, 1'b0);
    tk(); outs("b2b.BB", 8'hBB, 1'b1, 1'b1, 1'b1);
    tk(); outs("b2b.done", 8'h00, 1'b0, 1'b0, 1'b1);

    // Backpressure on lane 1; p_val stays high but must not be taken.
    p = 32'h44332211; p_cnt = 2'd3; p_val = 1'b1;
    tk(); p = 32'h99999999;
    outs("bp.11", 8'h11, 1'b0, 1'b1, 1'b0);
    tk(); c_rdy = 1'b0;
    outs("bp.hold0", 8'h22, 1'b0, 1'b1, 1'b0);
    tk(); outs("bp.hold1", 8'h22, 1'b0, 1'b1, 1'b0);
    tk(); outs("bp.hold2", 8'h22, 1'b0, 1'b1, 1'b0);
    tk(); c_rdy = 1'b1; p_val = 1'b0;
    outs("bp.22", 8'h22, 1'b0, 1'b1, 1'b0);
    tk(); outs("bp.33", 8'h33, 1'b0, 1'b1, 1'b0);
    tk(); outs("bp.44", 8'h44, 1'b1, 1'b1, 1'b1);
    tk(); outs("bp.done", 8'h00, 1'b0, 1'b0, 1'b1);

    // Single-lane words stream at one per cycle.
    p = 32'h000000A1; p_cnt = 2'd0; p_val = 1'b1;
    tk(); p = 32'h000000A2;
    outs("one.A1", 8'hA1, 1'b1, 1'b1, 1'b1);
    tk(); p = 32'h000000A3;
    outs("one.A2", 8'hA2, 1'b1, 1'b1, 1'b1);
    tk(); p_val = 1'b0;
    outs("one.A3", 8'hA3, 1'b1, 1'b1, 1'b1);
    tk(); outs("one.done", 8'h00, 1'b0, 1'b0, 1'b1);

    // Partial word on N=4 (three lanes) alongside a clamped count on N=3.
    p  = 32'h44332211; p_cnt  = 2'd2; p_val  = 1'b1;
    p3 = 24'h332211;   p3_cnt = 2'd3; p3_val = 1'b1;
    #1 chk("n3.p_rdy", {31'b0, p3_rdy}, 32'd1);
    tk(); p_val = 1'b0; p3_val = 1'b0;
    outs("part.11", 8'h11, 1'b0, 1'b1, 1'b0);
    outs3("n3.11", 8'h11, 1'b0, 1'b1);
    tk(); outs("part.22", 8'h22, 1'b0, 1'b1, 1'b0);
    outs3("n3.22", 8'h22, 1'b0, 1'b1);
    tk(); outs("part.33", 8'h33, 1'b1, 1'b1, 1'b1);
    outs3("n3.33", 8'h33, 1'b1, 1'b1);
    tk(); outs("part.done", 8'h00, 1'b0, 1'b0, 1'b1);
    outs3("n3.done", 8'h00, 1'b0, 1'b0);

    // Reset mid-word discards the remaining lanes.
    p = 32'h44332211; p_cnt = 2'd3; p_val = 1'b1;
    tk(); p_val = 1'b0;
    outs("mid.11", 8'h11, 1'b0, 1'b1, 1'b0);
    tk(); outs("mid.22", 8'h22, 1'b0, 1'b1, 1'b0);
    arst = 1'b1;
    outs("mid.rst", 8'h00, 1'b0, 1'b0, 1'b1);
    chk("mid.rst.c", {24'b0, c}, 32'd0);
    tk(); #2 arst = 1'b0;
    tk(); outs("mid.after", 8'h00, 1'b0, 1'b0, 1'b1);
    p = 32'h88776655; p_cnt = 2'd3; p_val = 1'b1;
    tk(); p_val = 1'b0;
    outs("mid.55", 8'h55, 1'b0, 1'b1, 1'b0);
    tk(); outs("mid.66", 8'h66, 1'b0, 1'b1, 1'b0);
    tk(); outs("mid.77", 8'h77, 1'b0, 1'b1, 1'b0);
    tk(); outs("mid.88", 8'h88, 1'b1, 1'b1, 1'b1);
    tk(); outs("mid.done", 8'h00, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
